// File: rtl/rx_eth_pkg.sv
// rx_eth_pkg: shared state encodings and frame constants for the Ethernet receiver
package rx_eth_pkg;
  typedef enum logic [2:0] {IDLE, PREA, HEAD, DATA, CHECK, DROP} state_t;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int HDR_LEN = 14;
  localparam int FCS_LEN = 4;
  localparam int MAX_PRE = 7;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam int ERR_FCS = 0;
  localparam int ERR_RUNT = 1;
  localparam int ERR_LEN = 2;
endpackage

// File: rtl/eth_fcs.sv
// eth_fcs: byte-wide Ethernet CRC-32, output arranged so Crc[31:24] is the first FCS byte on the wire
module eth_fcs (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  Data_in,
  input  logic        Enable,
  output logic [31:0] Crc
);
  logic [31:0] c, n;
  // reflected CRC-32 update over one byte, LSB first
  always_comb begin
    n = c;
    for (int i = 0; i < 8; i++) n = (n >> 1) ^ ((n[0] ^ Data_in[i]) ? 32'hEDB8_8320 : 32'h0);
  end
  // running remainder, preset to all ones at frame start
  always_ff @(posedge Clk) begin
    if (Reset) c <= '1;
    else if (Enable) c <= n;
  end
  assign Crc = ~{c[7:0], c[15:8], c[23:16], c[31:24]};
endmodule

// File: rtl/rx_eth.sv
// rx_eth: Ethernet frame receiver with preamble/SFD detect, address filter, FCS strip and check
module rx_eth
  import rx_eth_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_PRE = 1
) (
  input  logic        s_axis_aclk,
  input  logic        reset,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic [47:0] local_mac,
  input  logic        promisc,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type,
  output logic        rx_done,
  output logic        rx_ok,
  output logic [2:0]  rx_err
);
  localparam logic [10:0] MIN_FRAME = 11'(HDR_LEN + 1 + FCS_LEN);
  state_t st, nx;
  logic [10:0] cnt;
  logic [2:0] pcnt;
  logic [4:0][7:0] sr;
  logic tv_q, in_frame, pass, emit, runt;
  logic [31:0] crc;
  logic [2:0] err;
  assign in_frame = st == HEAD || st == DATA;
  assign pass = dst_mac == local_mac || dst_mac == BCAST_MAC || promisc;
  assign emit = st == DATA && cnt >= MIN_FRAME;
  assign runt = cnt < MIN_FRAME;
  // sr[4] is the oldest withheld byte; it is known not to be FCS once a newer byte or end-of-frame arrives
  eth_fcs u_fcs (
    .Clk(s_axis_aclk),
    .Reset(reset || st == IDLE),
    .Data_in(sr[4]),
    .Enable(in_frame && cnt >= 11'(FCS_LEN + 1)),
    .Crc(crc)
  );
  // end-of-frame status flags
  always_comb begin
    err = '0;
    err[ERR_LEN] = cnt > 11'(MAX_LEN);
    err[ERR_RUNT] = runt;
    err[ERR_FCS] = !runt && sr[3:0] != crc;
  end
  // next-state logic
  always_comb begin
    nx = st;
    case (st)
      IDLE: if (s_axis_tvalid) nx = (!tv_q && s_axis_tdata == PRE_BYTE) ? PREA : DROP;
      PREA: if (!s_axis_tvalid) nx = IDLE;
            else if (s_axis_tdata == SFD_BYTE) nx = pcnt >= 3'(MIN_PRE) ? HEAD : DROP;
            else if (s_axis_tdata != PRE_BYTE || pcnt == 3'(MAX_PRE)) nx = DROP;
      HEAD: if (cnt == 11'd6 && !pass) nx = DROP;
            else if (!s_axis_tvalid) nx = CHECK;
            else if (cnt == 11'(HDR_LEN - 1)) nx = DATA;
      DATA: if (!s_axis_tvalid) nx = CHECK;
      CHECK: nx = s_axis_tvalid ? DROP : IDLE;
      DROP: if (!s_axis_tvalid) nx = IDLE;
      default: nx = IDLE;
    endcase
  end
  // state, counters, header capture, byte pipeline and registered outputs
  always_ff @(posedge s_axis_aclk) begin
    if (reset) begin
      st <= IDLE;
      tv_q <= 1'b1;
      cnt <= '0;
      pcnt <= '0;
      sr <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser <= 1'b0;
      m_axis_tlast <= 1'b0;
      dst_mac <= '0;
      src_mac <= '0;
      eth_type <= '0;
      rx_done <= 1'b0;
      rx_ok <= 1'b0;
      rx_err <= '0;
    end else begin
      st <= nx;
      tv_q <= s_axis_tvalid;
      pcnt <= st == PREA ? pcnt + 3'd1 : 3'd1;
      cnt <= (st == IDLE || st == PREA) ? '0 : cnt + {10'd0, in_frame && s_axis_tvalid && cnt != '1};
      if (in_frame && s_axis_tvalid) sr <= {sr[3:0], s_axis_tdata};
      if (st == HEAD && s_axis_tvalid) begin
        if (cnt < 11'd6) dst_mac <= {dst_mac[39:0], s_axis_tdata};
        else if (cnt < 11'd12) src_mac <= {src_mac[39:0], s_axis_tdata};
        else eth_type <= {eth_type[7:0], s_axis_tdata};
      end
      if (emit) m_axis_tdata <= sr[4];
      m_axis_tvalid <= emit;
      m_axis_tuser <= emit && cnt == MIN_FRAME;
      m_axis_tlast <= emit && !s_axis_tvalid;
      rx_done <= st == CHECK;
      rx_ok <= st == CHECK && err == '0;
      rx_err <= st == CHECK ? err : '0;
    end
  end
endmodule

// File: tb/tb_rx_eth.sv
// tb_rx_eth: table-driven frame vectors plus back-to-back, short-gap and mid-frame reset sequences
module tb_rx_eth;
  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    string name;
    int npre;
    bit bad_pre;
    logic [47:0] dst;
    bit prom;
    int plen;
    logic [7:0] seed;
    bit flip;
    int trunc;
    int beats;
    int done;
    logic [2:0] err;
  } vec_t;
  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] FOREIGN = 48'h02_00_00_00_00_99;
  localparam logic [47:0] SRC = 48'h02_00_00_00_00_AA;
  localparam logic [15:0] TYPE = 16'h0800;
  logic s_axis_aclk = 1'b0, reset = 1'b1, s_axis_tvalid = 1'b0, promisc = 1'b0;
  logic [7:0] s_axis_tdata = '0;
  logic [47:0] local_mac = LOCAL;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tuser, m_axis_tlast, rx_done, rx_ok;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] eth_type;
  logic [2:0] rx_err, last_err;
  byte_q_t fb, pay, got, saved;
  int n_vec = 0, n_bad = 0;
  int n_user, n_last, user_at, last_at, n_done, n_ok;
  vec_t tbl[$];
  rx_eth dut (
    .s_axis_aclk(s_axis_aclk), .reset(reset), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .local_mac(local_mac), .promisc(promisc), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .dst_mac(dst_mac), .src_mac(src_mac),
    .eth_type(eth_type), .rx_done(rx_done), .rx_ok(rx_ok), .rx_err(rx_err)
  );
  always #5 s_axis_aclk = ~s_axis_aclk;
  // output monitor, sampled on the falling edge
  always @(negedge s_axis_aclk) begin
    if (m_axis_tvalid) begin
      if (m_axis_tuser) begin n_user++; user_at = got.size(); end
      if (m_axis_tlast) begin n_last++; last_at = got.size(); end
      got.push_back(m_axis_tdata);
    end
    if (rx_done) begin n_done++; n_ok += int'(rx_ok); last_err = rx_err; end
  end
  function automatic vec_t mk(string n, int npre, bit bad_pre, logic [47:0] dst, bit prom, int plen,
                              logic [7:0] seed, bit flip, int trunc, int beats, int done, logic [2:0] err);
    mk.name = n; mk.npre = npre; mk.bad_pre = bad_pre; mk.dst = dst; mk.prom = prom; mk.plen = plen;
    mk.seed = seed; mk.flip = flip; mk.trunc = trunc; mk.beats = beats; mk.done = done; mk.err = err;
  endfunction
  function automatic logic [31:0] crc32(input byte_q_t q);
    logic [31:0] c = '1;
    foreach (q[i]) begin
      c = c ^ {24'd0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
    end
    return ~c;
  endfunction
  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
    n_vec++;
    if (g !== e) begin n_bad++; $display("FAIL %s: got %0h want %0h", nm, g, e); end
  endtask
  task automatic clear_mon();
    got.delete(); n_user = 0; n_last = 0; user_at = -1; last_at = -1; n_done = 0; n_ok = 0; last_err = '0;
  endtask
  task automatic build(input vec_t v);
    byte_q_t body;
    logic [111:0] hdr = {v.dst, SRC, TYPE};
    logic [31:0] f;
    fb.delete(); pay.delete();
    repeat (v.npre) fb.push_back(8'h55);
    if (v.bad_pre) fb.push_back(8'h54);
    fb.push_back(8'hD5);
    for (int i = 13; i >= 0; i--) body.push_back(hdr[i*8 +: 8]);
    for (int i = 0; i < v.plen; i++) body.push_back(v.seed + 8'(i));
    f = crc32(body);
    for (int i = 0; i < 4; i++) body.push_back(f[i*8 +: 8]);
    if (v.flip) body[20] = body[20] ^ 8'h04;
    while (v.trunc > 0 && body.size() > v.trunc) void'(body.pop_back());
    for (int i = 14; i < body.size() - 4; i++) pay.push_back(body[i]);
    foreach (body[i]) fb.push_back(body[i]);
  endtask
  task automatic drive(input int gap);
    foreach (fb[i]) begin @(negedge s_axis_aclk); s_axis_tdata = fb[i]; s_axis_tvalid = 1'b1; end
    @(negedge s_axis_aclk); s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    repeat (gap - 1) @(negedge s_axis_aclk);
  endtask
  task automatic check(input string nm, input int eb, input int nf, input int ed, input logic [2:0] ee,
                       input int eok, input logic [47:0] edst);
    int bad = 0;
    chk({nm, ".beats"}, got.size(), eb);
    chk({nm, ".tuser_cnt"}, n_user, nf);
    chk({nm, ".tlast_cnt"}, n_last, nf);
    chk({nm, ".done_cnt"}, n_done, ed);
    chk({nm, ".ok_cnt"}, n_ok, eok);
    if (eb > 0) begin
      foreach (pay[i]) if (i < got.size() && got[i] !== pay[i]) bad++;
      chk({nm, ".data_miscompares"}, bad, 0);
      chk({nm, ".tuser_at"}, user_at, eb - eb / nf);
      chk({nm, ".tlast_at"}, last_at, eb - 1);
      chk({nm, ".dst_mac"}, dst_mac, edst);
      chk({nm, ".src_mac"}, src_mac, SRC);
      chk({nm, ".eth_type"}, eth_type, TYPE);
    end
    if (ed > 0) chk({nm, ".rx_err"}, last_err, ee);
  endtask
  task automatic run_vec(input vec_t v);
    promisc = v.prom;
    build(v);
    @(posedge s_axis_aclk); clear_mon();
    drive(12);
    check(v.name, v.beats, v.beats > 0 ? 1 : 0, v.done, v.err, (v.done > 0 && v.err == 3'b000) ? 1 : 0, v.dst);
  endtask
  initial begin
    vec_t v;
    tbl.push_back(mk("good46",      7, 0, LOCAL,     0,   46, 8'h00, 0, 0,   46, 1, 3'b000));
    tbl.push_back(mk("fcs_flip",    7, 0, LOCAL,     0,   46, 8'h00, 1, 0,   46, 1, 3'b001));
    tbl.push_back(mk("foreign",     7, 0, FOREIGN,   0,   46, 8'h10, 0, 0,    0, 0, 3'b000));
    tbl.push_back(mk("promisc",     7, 0, FOREIGN,   1,   46, 8'h10, 0, 0,   46, 1, 3'b000));
    tbl.push_back(mk("bad_pre",     1, 1, LOCAL,     0,   46, 8'h00, 0, 0,    0, 0, 3'b000));
    tbl.push_back(mk("runt10",      7, 0, LOCAL,     0,   46, 8'h00, 0, 10,   0, 1, 3'b010));
    tbl.push_back(mk("bcast64",     7, 0, BCAST(),   0,   64, 8'h80, 0, 0,   64, 1, 3'b000));
    tbl.push_back(mk("min19",       1, 0, LOCAL,     0,    1, 8'h5A, 0, 0,    1, 1, 3'b000));
    tbl.push_back(mk("short18",     3, 0, LOCAL,     0,    0, 8'h00, 0, 0,    0, 1, 3'b010));
    tbl.push_back(mk("pre8",        8, 0, LOCAL,     0,   46, 8'h00, 0, 0,    0, 0, 3'b000));
    tbl.push_back(mk("no_pre",      0, 0, LOCAL,     0,   46, 8'h00, 0, 0,    0, 0, 3'b000));
    tbl.push_back(mk("max1518",     7, 0, LOCAL,     0, 1500, 8'h33, 0, 0, 1500, 1, 3'b000));
    tbl.push_back(mk("over1519",    7, 0, LOCAL,     0, 1501, 8'h33, 0, 0, 1501, 1, 3'b100));
    repeat (3) @(negedge s_axis_aclk);
    reset = 1'b0;
    clear_mon();
    chk("reset.m_axis", {m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast}, '0);
    chk("reset.status", {rx_done, rx_ok, rx_err}, '0);
    chk("reset.header", {dst_mac, src_mac}, '0);
    chk("reset.eth_type", eth_type, '0);
    repeat (2) @(negedge s_axis_aclk);
    foreach (tbl[i]) run_vec(tbl[i]);
    // two 64-byte frames separated by the minimum 2-cycle gap
    promisc = 1'b0;
    build(mk("b2b_a", 7, 0, LOCAL, 0, 64, 8'h01, 0, 0, 0, 0, 3'b000));
    saved = pay;
    @(posedge s_axis_aclk); clear_mon();
    drive(2);
    build(mk("b2b_b", 7, 0, LOCAL, 0, 64, 8'hC0, 0, 0, 0, 0, 3'b000));
    pay = {saved, pay};
    drive(12);
    check("b2b", 128, 2, 2, 3'b000, 2, LOCAL);
    // second frame rises while the first is still in CHECK: only the first is received
    build(mk("gap1_a", 7, 0, LOCAL, 0, 46, 8'h21, 0, 0, 0, 0, 3'b000));
    saved = pay;
    @(posedge s_axis_aclk); clear_mon();
    drive(1);
    build(mk("gap1_b", 7, 0, LOCAL, 0, 46, 8'h77, 0, 0, 0, 0, 3'b000));
    drive(12);
    pay = saved;
    check("gap1", 46, 1, 1, 3'b000, 1, LOCAL);
    // reset pulsed while payload byte 20 is on the line
    build(mk("rst_mid", 7, 0, LOCAL, 0, 46, 8'h40, 0, 0, 0, 0, 3'b000));
    @(posedge s_axis_aclk); clear_mon();
    foreach (fb[i]) begin
      @(negedge s_axis_aclk);
      if (i == 42) chk("rst.busy_before", m_axis_tvalid, 1'b1);
      if (i == 43) begin
        chk("rst.m_axis_after", {m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast}, '0);
        chk("rst.status_after", {rx_done, rx_ok, rx_err}, '0);
        chk("rst.header_after", {dst_mac, src_mac}, '0);
      end
      reset = (i == 42);
      s_axis_tdata = fb[i];
      s_axis_tvalid = 1'b1;
    end
    @(negedge s_axis_aclk); s_axis_tvalid = 1'b0;
    repeat (11) @(negedge s_axis_aclk);
    chk("rst.tlast_cnt", n_last, 0);
    chk("rst.done_cnt", n_done, 0);
    run_vec(mk("after_rst", 7, 0, LOCAL, 0, 46, 8'h90, 0, 0, 46, 1, 3'b000));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  function automatic logic [47:0] BCAST();
    return 48'hFFFF_FFFF_FFFF;
  endfunction
endmodule

// File: doc/rx_eth.md
RX_ETH -- requirements
Module: rx_eth

Interface
REQ-001 MAX_LEN, 1518, maximum post-SFD frame bytes, FCS included.
REQ-002 MIN_PRE, 1, minimum count of 0x55 preamble bytes before the 0xD5 SFD.
REQ-003 s_axis_aclk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 s_axis_tdata  in  8  line byte stream: preamble, SFD, header, payload, FCS.
REQ-006 s_axis_tvalid  in  1  high for the whole frame, contiguous; falling edge = end of frame.
REQ-007 local_mac  in  48  station address for the destination filter.
REQ-008 promisc  in  1  1 = accept any destination.
REQ-009 m_axis_tdata  out  8  payload byte, FCS stripped.
REQ-010 m_axis_tvalid  out  1  payload byte valid; no backpressure.
REQ-011 m_axis_tuser  out  1  high on the first payload beat of a frame.
REQ-012 m_axis_tlast  out  1  high on the last payload beat of a frame.
REQ-013 dst_mac / src_mac / eth_type  out  48/48/16  header fields, valid from the first payload beat until the next SFD.
REQ-014 rx_done  out  1  one-cycle end-of-frame status strobe.
REQ-015 rx_ok  out  1  qualifies rx_done: frame accepted.
REQ-016 rx_err  out  3  qualifies rx_done: {len_err, runt_err, fcs_err}.

Function
REQ-017 FSM states: IDLE, PREA, HEAD, DATA, CHECK, DROP.
REQ-018 IDLE -> PREA on a sampled s_axis_tvalid rising edge, and only if the byte is 0x55; any other first byte -> DROP.
REQ-019 PREA counts 0x55 bytes; 0xD5 after >= MIN_PRE of them -> HEAD; any other byte, or more than 7 bytes of 0x55 -> DROP.
REQ-020 HEAD captures 14 bytes MSB-first: dst_mac, then src_mac, then eth_type.
REQ-021 After byte 6, the destination filter passes if dst == local_mac, dst == 48'hFFFF_FFFF_FFFF, or promisc = 1; on fail -> DROP, with no payload and no rx_done.
REQ-022 Post-SFD bytes pass through a 5-deep byte shift register, so the 4 newest bytes are always withheld as candidate FCS.
REQ-023 Payload byte sampled at edge E is presented on m_axis_* after edge E+5 (latency 5); m_axis_tvalid is contiguous within the frame.
REQ-024 m_axis_tlast = 1 on the beat loaded in the cycle s_axis_tvalid is sampled low.
REQ-025 CRC-32 is computed over header and payload bytes only, via eth_fcs, which is reset in IDLE.
REQ-026 Received FCS is the last 4 bytes, first-received = Crc[31:24]; mismatch sets fcs_err.
REQ-027 Fewer than 19 post-SFD bytes (14 header + 1 payload + 4 FCS) -> runt_err; no payload is emitted for a runt.
REQ-028 More than MAX_LEN post-SFD bytes -> len_err; the 11-bit byte counter saturates; payload keeps flowing and the frame ends with tlast.
REQ-029 CHECK lasts exactly one cycle, the cycle after the tlast beat (or after tvalid falls for a runt): rx_done = 1, rx_ok = (rx_err == 0), then -> IDLE.
REQ-030 DROP waits for s_axis_tvalid low, then -> IDLE; no outputs are produced.
REQ-031 Minimum inter-frame gap is 2 idle cycles; a frame whose tvalid rises during CHECK is treated as DROP.

Reset
REQ-032 On reset: FSM -> IDLE; counters, shift register and eth_fcs cleared; m_axis_tvalid/tuser/tlast, rx_done, rx_ok, rx_err = 0; m_axis_tdata = 0; dst_mac/src_mac/eth_type = 0.
REQ-033 Reset asserted mid-frame aborts the frame without a tlast or rx_done; after release, a frame already in progress (tvalid high) is ignored until tvalid goes low.

Structure
REQ-034 Shared package holds: state encodings, preamble/SFD constants (8'h55, 8'hD5), header length 14, FCS length 4, the broadcast MAC, and rx_err bit positions.
REQ-035 One sub-module: the existing eth_fcs, instantiated once with Clk/Reset/Data_in/Enable/Crc.

Verification
REQ-036 7x 0x55, 0xD5, dst = local_mac, 46-byte payload 0x00..0x2D, correct FCS -> 46 beats, tuser on 0x00, tlast on 0x2D, rx_done with rx_ok = 1, rx_err = 0.
REQ-037 Same frame with one payload bit flipped -> 46 beats emitted, rx_done with rx_ok = 0, rx_err = 3'b001.
REQ-038 dst = 02:00:00:00:00:99, local_mac different, promisc = 0 -> no m_axis_tvalid, no rx_done; repeat with promisc = 1 -> frame accepted.
REQ-039 Preamble 0x55, 0x54, 0xD5 -> DROP; no outputs. 10-byte post-SFD frame -> rx_err = 3'b010, no payload.
REQ-040 Loopback from tx_eth, 64-byte payload, two frames with a 2-cycle gap -> both frames received byte-exact with rx_ok = 1.
REQ-041 reset pulsed at payload byte 20 -> outputs 0 the next cycle; the frame is discarded; the next clean frame is received with rx_ok = 1.
